div: RTL and testbench
======================

Name: div

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU, sitting beside the EX stage.
- Takes operands and start from EX and returns a 64-bit {remainder, quotient} that EX writes to HI/LO.
- EX holds its pipeline stall request high while a division is in flight.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
DATA_W, 32, operand width; result is 2*DATA_W; the iteration counter is wide enough to hold DATA_W.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset
signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
opdata1_i  in  DATA_W  dividend (rs)
opdata2_i  in  DATA_W  divisor (rt)
start_i  in  1  request; EX holds it high until it sees ready_o
annul_i  in  1  abort the in-flight division (flush)
result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}, registered
ready_o  out  1  result valid, registered

Behaviour:
- Reset: rst is synchronous, active-high. On it: state=FREE, result_o=0, ready_o=0, counter=0. Reset overrides any state, including mid-division.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0 -> BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON. Latch |dividend| and |divisor| (two's-complement negate only when signed_div_i=1 and the MSB is set). Latch both operand sign bits and signed_div_i. Clear the counter and partial remainder.
  - Otherwise stay in FREE; ready_o=0, result_o=0.
- BYZERO: next edge -> END with result_o=0, ready_o=1.
- ON, annul_i=1: -> FREE; result_o=0, ready_o=0. No partial result is ever exposed.
- ON, counter<32: per edge, shift the partial remainder left, bringing in the next dividend MSB.
  - Trial subtract divisor.
  - If non-negative: keep the difference, quotient bit=1.
  - Else: keep the shifted value, quotient bit=0.
  - counter++.
- ON, counter==32: next edge applies signs and moves to END with ready_o=1.
  - Quotient is negated if signed and the operand signs differ.
  - Remainder is negated if signed and the dividend was negative.
- END:
  - While start_i=1: hold result_o and ready_o=1.
  - When start_i=0: -> FREE, ready_o=0, result_o=0.
  - annul_i in END behaves like start_i=0.
- Latency: counting the accepting edge as edge 1, ready_o rises after edge 34 for a normal divide and after edge 2 for divide-by-zero.
- Inputs are sampled only in FREE; operand changes during ON/END are ignored.
- Signed corner case: 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0. No trap, no flag.
- Back-to-back: a new request is accepted no earlier than the edge after returning to FREE, so EX must drop start_i for at least one cycle.

Optional Feature:
DIV_EARLY_OUT_EN.
- Defined: in FREE, if |divisor| > |dividend| (unsigned compare of magnitudes) and the divisor is nonzero, go directly to END. Quotient=0, remainder=original opdata1_i (sign preserved); ready_o rises after edge 2.
- Undefined: every nonzero-divisor request takes the full 34-edge path. Results are identical in both builds; only latency differs.

Test Plan:
1. Unsigned: DIVU 100 / 7, start held -> ready_o after edge 34. result_o = {0x00000002, 0x0000000E}. Drop start -> ready_o=0 and result_o=0 next edge.
2. Signed: DIV -7 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also DIV 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001. Also DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
3. Divide-by-zero: DIVU 5 / 0 -> ready_o after edge 2, result_o=0. Hold start 5 extra cycles -> outputs stable.
4. Annul: start 0xFFFFFFFF / 3, pulse annul_i at counter=10 -> FREE next edge, ready_o never asserted. A new request 9 / 3 issued two cycles later -> quotient 3, remainder 0.
5. Reset mid-op: assert rst at counter=20 -> on the next edge state=FREE, ready_o=0, result_o=0. Operand changes during ON do not alter a concurrent clean run's result.
6. DIV_EARLY_OUT_EN: DIVU 3 / 10 -> ready_o after edge 2 with {3, 0} when defined, after edge 34 with the same value when undefined.

Source files
------------

// File: rtl/div.sv
// Radix-2 restoring 32-bit divider beside EX for DIV/DIVU.
// Define DIV_EARLY_OUT_EN to skip the loop when |divisor| > |dividend|.
module div #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o
);

  localparam int CW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_FREE,
    S_BYZERO,
    S_ON,
    S_END
  } state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] dsr_q;
  logic [DATA_W-1:0] rem_q;
  logic              neg1_q;
  logic              neg2_q;
  logic              sgn_q;

  logic              neg1;
  logic              neg2;
  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   shift;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] rem_d;
  logic [DATA_W-1:0] quo_d;
  logic [DATA_W-1:0] q_fin;
  logic [DATA_W-1:0] r_fin;

  // Operand magnitudes in FREE; only signed requests negate.
  always_comb begin
    neg1 = signed_div_i & opdata1_i[DATA_W-1];
    neg2 = signed_div_i & opdata2_i[DATA_W-1];
    abs1 = neg1 ? ({DATA_W{1'b0}} - opdata1_i) : opdata1_i;
    abs2 = neg2 ? ({DATA_W{1'b0}} - opdata2_i) : opdata2_i;
  end

  // One restoring step: shift in the next dividend bit, trial subtract.
  always_comb begin
    shift = {rem_q, dvd_q[DATA_W-1]};
    diff  = shift - {1'b0, dsr_q};
    rem_d = shift[DATA_W-1:0];
    quo_d = {dvd_q[DATA_W-2:0], 1'b0};
    if (!diff[DATA_W]) begin
      rem_d = diff[DATA_W-1:0];
      quo_d = {dvd_q[DATA_W-2:0], 1'b1};
    end
  end

  // Sign fix-up applied on the final edge of the loop.
  always_comb begin
    q_fin = dvd_q;
    r_fin = rem_q;
    if (sgn_q && (neg1_q ^ neg2_q))
      q_fin = {DATA_W{1'b0}} - dvd_q;
    if (sgn_q && neg1_q)
      r_fin = {DATA_W{1'b0}} - rem_q;
  end

  // Divider FSM with registered result/ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      sgn_q    <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state_q)
        S_FREE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              dvd_q   <= '0;
              state_q <= S_BYZERO;
`ifdef DIV_EARLY_OUT_EN
            end else if (abs2 > abs1) begin
              dvd_q   <= opdata1_i;
              state_q <= S_BYZERO;
`endif
            end else begin
              dvd_q   <= abs1;
              dsr_q   <= abs2;
              rem_q   <= '0;
              cnt_q   <= '0;
              neg1_q  <= neg1;
              neg2_q  <= neg2;
              sgn_q   <= signed_div_i;
              state_q <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          result_o <= {dvd_q, {DATA_W{1'b0}}};
          ready_o  <= 1'b1;
          state_q  <= S_END;
        end
        S_ON: begin
          if (annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state_q  <= S_FREE;
          end else if (cnt_q == CW'(DATA_W)) begin
            result_o <= {r_fin, q_fin};
            ready_o  <= 1'b1;
            state_q  <= S_END;
          end else begin
            rem_q <= rem_d;
            dvd_q <= quo_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_END: begin
          if (!start_i || annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b0;
            state_q  <= S_FREE;
          end
        end
        default: state_q <= S_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the div block.
// Expected values are hand-computed quotient/remainder pairs.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int errors = 0;
  int checks = 0;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
  localparam int EO_LAT = 2;
`else
  localparam int EO_LAT = 34;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, measure latency, check result, hold, release.
  task automatic do_div(input string tag,
                        input logic sg,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int lat,
                        input logic [63:0] exp,
                        input int hold);
    int n;
    signed_div_i = sg;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ready_o && n < 60);
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_res"}, result_o, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold"}, {63'(0), ready_o}, 64'd1);
      chk({tag, "_holdres"}, result_o, exp);
    end
    start_i = 1'b0;
    tick();
    chk({tag, "_drop_rdy"}, {63'(0), ready_o}, 64'd0);
    chk({tag, "_drop_res"}, result_o, 64'd0);
  endtask

  initial begin
    int n;
    logic seen;
    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    tick();
    tick();
    chk("reset_rdy", {63'(0), ready_o}, 64'd0);
    chk("reset_res", result_o, 64'd0);
    rst = 1'b0;
    tick();

    do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 34,
           {32'd2, 32'd14}, 1);
    do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34,
           {32'h0000_0001, 32'hFFFF_FFFD}, 0);
    do_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34,
           {32'h0, 32'h8000_0000}, 0);
    do_div("div_m8_m3", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 34,
           {32'hFFFF_FFFE, 32'h0000_0002}, 0);
    do_div("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 34,
           {32'h0, 32'hFFFF_FFFF}, 0);
    do_div("divu_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34,
           {32'h0, 32'h1}, 0);
    do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 64'd0, 5);

    // Annul mid-loop: counter reaches 10 after edge 11.
    signed_div_i = 1'b0;
    opdata1_i    = 32'hFFFF_FFFF;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      seen |= ready_o;
    end
    annul_i = 1'b1;
    tick();
    seen |= ready_o;
    chk("annul_res", result_o, 64'd0);
    annul_i = 1'b0;
    start_i = 1'b0;
    tick();
    seen |= ready_o;
    tick();
    seen |= ready_o;
    chk("annul_never_rdy", {63'(0), seen}, 64'd0);
    do_div("after_annul_9_3", 1'b0, 32'd9, 32'd3, 34,
           {32'd0, 32'd3}, 0);

    // Reset mid-loop at counter 20.
    signed_div_i = 1'b0;
    opdata1_i    = 32'hFFFF_FFFF;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    for (int i = 0; i < 21; i++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_rdy", {63'(0), ready_o}, 64'd0);
    chk("rst_mid_res", result_o, 64'd0);
    rst     = 1'b0;
    start_i = 1'b0;
    tick();
    do_div("after_rst_50_6", 1'b0, 32'd50, 32'd6, 34,
           {32'd2, 32'd8}, 0);

    // Operand churn during the loop must not disturb the result.
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd10;
    start_i      = 1'b1;
    tick();
    n = 1;
    signed_div_i = 1'b1;
    opdata1_i    = 32'hDEAD_BEEF;
    opdata2_i    = 32'd0;
    while (!ready_o && n < 60) begin
      tick();
      n++;
      opdata1_i = opdata1_i + 32'd17;
    end
    chk("churn_lat", 64'(n), 64'd34);
    chk("churn_res", result_o, {32'd0, 32'd100});
    start_i = 1'b0;
    tick();

    do_div("divu_3_10", 1'b0, 32'd3, 32'd10, EO_LAT,
           {32'd3, 32'd0}, 0);
    do_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, EO_LAT,
           {32'hFFFF_FFFD, 32'd0}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
